imm_encode: RTL and testbench
=============================

IMM_ENCODE -- requirements
Module: imm_encode

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the saturating error counter.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1: request present.
REQ-005 SHALL have port in_ready  output  1: request accepted when in_valid & in_ready.
REQ-006 SHALL have port in_op  input  2: format; 00 I, 01 S, 10 B, 11 J.
REQ-007 SHALL have port in_imm  input  32: signed immediate value to encode.
REQ-008 SHALL have port in_base  input  32: instruction template supplying all non-immediate bits.
REQ-009 SHALL have port out_valid  output  1: encoded result present.
REQ-010 SHALL have port out_ready  input  1: consumer takes result when out_valid & out_ready.
REQ-011 SHALL have port out_instr  output  32: template with immediate fields overwritten.
REQ-012 SHALL have port out_err  output  1: immediate not representable in the selected format.
REQ-013 SHALL have port err_clr  input  1: clears err_count.
REQ-014 SHALL have port err_count  output  CNT_W: number of errored results consumed, saturating.

Function
REQ-015 I: out_instr[31:20]=imm[11:0]; err unless imm[31:11] all equal.
REQ-016 S: [31:25]=imm[11:5], [11:7]=imm[4:0]; err unless imm[31:11] all equal.
REQ-017 B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; err unless imm[31:12] all equal and imm[0]=0.
REQ-018 J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; err unless imm[31:20] all equal and imm[0]=0.
REQ-019 All bits not named for the selected format SHALL equal in_base; on error the truncated encoding SHALL still be output.
REQ-020 Two-stage pipeline: stage 1 registers op/imm/base and computes err; stage 2 registers out_instr/out_err; out_valid asserts exactly 2 cycles after acceptance absent stall.
REQ-021 stall = out_valid & ~out_ready; in_ready = ~stall; under stall both stages and all outputs SHALL hold unchanged.
REQ-022 Without stall, pipeline SHALL accept one request per cycle; bubbles (in_valid=0) propagate as valid=0 stage entries.
REQ-023 Results SHALL emerge in acceptance order; no request dropped or duplicated.
REQ-024 err_count SHALL increment by 1 on each output transfer with out_err=1; SHALL saturate at 2^CNT_W-1.
REQ-025 err_clr SHALL set err_count to 0 next cycle; err_clr with simultaneous errored transfer yields 0.

Reset
REQ-026 On rst: stage valids=0, out_valid=0, out_instr=0, out_err=0, err_count=0; in_ready=1 in the cycle after reset.
REQ-027 rst mid-operation SHALL discard all in-flight requests; rst overrides all other inputs.

Verification
REQ-028 I, imm=0xFFFFFFFF, base=0x00000013 -> out_instr=0xFFF00013, out_err=0, out_valid 2 cycles after accept.
REQ-029 B, imm=0x00000FFE, base=0x00000063 -> out_instr=0x7E000FE3, out_err=0; S, imm=0x00000800, base=0x00002023 -> out_instr=0x80002023, out_err=1.
REQ-030 J, imm=0x00000001 -> out_err=1; err_count 0->1 on transfer; err_clr same cycle as a second errored transfer -> err_count=0.
REQ-031 Back-to-back 3 requests, out_ready=0 for 3 cycles after first out_valid -> in_ready=0, outputs stable, all 3 delivered in order afterwards.
REQ-032 256 consecutive errored transfers with CNT_W=8 -> err_count holds 255.
REQ-033 rst asserted with 2 requests in flight -> out_valid=0 next cycle, neither request ever output.

Source files
------------

// File: rtl/imm_encode.sv
// Immediate encoder: merges a signed immediate into an instruction template
// for I/S/B/J formats, flagging values the format cannot represent.
module imm_encode #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] OP_I = 2'd0;
  localparam logic [1:0] OP_S = 2'd1;
  localparam logic [1:0] OP_B = 2'd2;

  logic             stall;
  logic             fits_12;
  logic             fits_13;
  logic             fits_21;
  logic             err_next;
  logic [31:0]      enc_instr;

  logic             s1_valid_reg;
  logic [1:0]       s1_op_reg;
  logic [31:0]      s1_imm_reg;
  logic [31:0]      s1_base_reg;
  logic             s1_err_reg;

  logic             out_valid_reg;
  logic [31:0]      out_instr_reg;
  logic             out_err_reg;
  logic [CNT_W-1:0] err_count_reg;

  assign stall    = out_valid_reg & ~out_ready;
  assign in_ready = ~stall;

  // A value fits an N-bit signed field when every bit above N-1 matches the sign.
  assign fits_12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits_13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits_21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    err_next = 1'b0;
    case (in_op)
      OP_I, OP_S: err_next = ~fits_12;
      OP_B:       err_next = ~fits_13 | in_imm[0];
      default:    err_next = ~fits_21 | in_imm[0];
    endcase
  end

  // Truncated encoding is produced even when the error flag is set.
  always_comb begin
    enc_instr = s1_base_reg;
    case (s1_op_reg)
      OP_I: enc_instr[31:20] = s1_imm_reg[11:0];
      OP_S: begin
        enc_instr[31:25] = s1_imm_reg[11:5];
        enc_instr[11:7]  = s1_imm_reg[4:0];
      end
      OP_B: begin
        enc_instr[31]    = s1_imm_reg[12];
        enc_instr[30:25] = s1_imm_reg[10:5];
        enc_instr[11:8]  = s1_imm_reg[4:1];
        enc_instr[7]     = s1_imm_reg[11];
      end
      default: begin
        enc_instr[31]    = s1_imm_reg[20];
        enc_instr[30:21] = s1_imm_reg[10:1];
        enc_instr[20]    = s1_imm_reg[11];
        enc_instr[19:12] = s1_imm_reg[19:12];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_op_reg     <= 2'd0;
      s1_imm_reg    <= 32'd0;
      s1_base_reg   <= 32'd0;
      s1_err_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_instr_reg <= 32'd0;
      out_err_reg   <= 1'b0;
    end else if (!stall) begin
      s1_valid_reg  <= in_valid;
      s1_op_reg     <= in_op;
      s1_imm_reg    <= in_imm;
      s1_base_reg   <= in_base;
      s1_err_reg    <= err_next;
      out_valid_reg <= s1_valid_reg;
      out_instr_reg <= enc_instr;
      out_err_reg   <= s1_err_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_count_reg <= '0;
    end else if (out_valid_reg && out_ready && out_err_reg && (err_count_reg != '1)) begin
      err_count_reg <= err_count_reg + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_err   = out_err_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_imm_encode.sv
// Bench for imm_encode: directed vector table, stall/reset/counter sequences,
// and randomized traffic scored against a field-placement reference model.
module tb_imm_encode;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_imm;
  logic [31:0]      in_base;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic             err_clr;
  logic [CNT_W-1:0] err_count;

  always #5 clk = ~clk;

  imm_encode #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_imm(in_imm), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .err_clr(err_clr), .err_count(err_count)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          transfers = 0;
  int          model_cnt = 0;
  logic [32:0] exp_q[$];

  function automatic logic [31:0] put(logic [31:0] w, int dst, int width, logic [31:0] val);
    logic [31:0] m;
    m = (32'h1 << width) - 32'h1;
    return (w & ~(m << dst)) | ((val & m) << dst);
  endfunction

  // Reference: representability by signed range, fields placed by shift/mask.
  function automatic logic [32:0] model(logic [1:0] op, logic [31:0] imm, logic [31:0] base);
    int          si;
    logic        err;
    logic [31:0] w;
    si = $signed(imm);
    w  = base;
    case (op)
      2'd0: begin
        err = !(si >= -2048 && si <= 2047);
        w = put(w, 20, 12, imm);
      end
      2'd1: begin
        err = !(si >= -2048 && si <= 2047);
        w = put(w, 25, 7, imm >> 5);
        w = put(w, 7, 5, imm);
      end
      2'd2: begin
        err = !(si >= -4096 && si <= 4095) || (imm[0] != 1'b0);
        w = put(w, 31, 1, imm >> 12);
        w = put(w, 25, 6, imm >> 5);
        w = put(w, 8, 4, imm >> 1);
        w = put(w, 7, 1, imm >> 11);
      end
      default: begin
        err = !(si >= -(1 << 20) && si <= (1 << 20) - 1) || (imm[0] != 1'b0);
        w = put(w, 31, 1, imm >> 20);
        w = put(w, 21, 10, imm >> 1);
        w = put(w, 20, 1, imm >> 11);
        w = put(w, 12, 8, imm >> 12);
      end
    endcase
    return {err, w};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One clock: score handshakes at the falling edge, then check the counter.
  task automatic cycle(output bit acc);
    logic [32:0] e;
    bit          xfer;
    acc  = 1'b0;
    xfer = 1'b0;
    @(negedge clk);
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_op, in_imm, in_base));
        acc = 1'b1;
      end
      if (out_valid && out_ready) begin
        xfer = 1'b1;
        transfers++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL xfer_unexpected got=%h exp=none", out_instr);
        end else begin
          e = exp_q.pop_front();
          check("xfer_instr", out_instr, e[31:0]);
          check("xfer_err", 32'(out_err), 32'(e[32]));
          $display("xfer %0d instr=%h err=%0d", transfers, out_instr, out_err);
        end
      end
      if (err_clr) model_cnt = 0;
      else if (xfer && out_err && model_cnt < CNT_MAX) model_cnt++;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      model_cnt = 0;
    end
    check("err_count", 32'(err_count), 32'(model_cnt));
  endtask

  task automatic drive(logic v, logic [1:0] op, logic [31:0] imm, logic [31:0] base);
    in_valid = v;
    in_op    = op;
    in_imm   = imm;
    in_base  = base;
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return 32'($signed($urandom_range(0, 4095)) - 2048);
      1:       return {{11{r[20]}}, r[20:0]};
      2:       return {{19{r[12]}}, r[12:0]};
      default: return r;
    endcase
  endfunction

  vec_t vecs[14];

  initial begin
    bit acc;
    int start_x;
    int idx;
    int hold;
    bit first_seen;
    logic [31:0] held_instr;

    vecs[0]  = '{2'd0, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b0};
    vecs[1]  = '{2'd2, 32'h00000FFE, 32'h00000063, 32'h7E000FE3, 1'b0};
    vecs[2]  = '{2'd1, 32'h00000800, 32'h00002023, 32'h80002023, 1'b1};
    vecs[3]  = '{2'd0, 32'h000007FF, 32'h00000000, 32'h7FF00000, 1'b0};
    vecs[4]  = '{2'd0, 32'hFFFFF800, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{2'd0, 32'h00000800, 32'h00000000, 32'h80000000, 1'b1};
    vecs[6]  = '{2'd3, 32'h00000001, 32'h0000006F, 32'h0000006F, 1'b1};
    vecs[7]  = '{2'd3, 32'h000FFFFE, 32'h0000006F, 32'h7FFFF06F, 1'b0};
    vecs[8]  = '{2'd3, 32'h00100000, 32'h00000000, 32'h80000000, 1'b1};
    vecs[9]  = '{2'd2, 32'hFFFFF000, 32'h00000063, 32'h80000063, 1'b0};
    vecs[10] = '{2'd2, 32'h00000002, 32'h00000000, 32'h00000100, 1'b0};
    vecs[11] = '{2'd2, 32'h00000003, 32'h00000000, 32'h00000100, 1'b1};
    vecs[12] = '{2'd1, 32'hFFFFFFFF, 32'h00000000, 32'hFE000F80, 1'b0};
    vecs[13] = '{2'd0, 32'h00000000, 32'hFFFFFFFF, 32'h000FFFFF, 1'b0};

    rst = 1'b1;
    out_ready = 1'b1;
    err_clr = 1'b0;
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    cycle(acc);
    cycle(acc);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    cycle(acc);

    // Directed vectors with latency check.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].imm, vecs[i].base);
      cycle(acc);
      check("vec_accept", 32'(acc), 32'd1);
      drive(1'b0, 2'd0, 32'd0, 32'd0);
      check("vec_lat1", 32'(out_valid), 32'd0);
      cycle(acc);
      check("vec_lat2", 32'(out_valid), 32'd1);
      check("vec_instr", out_instr, vecs[i].exp_instr);
      check("vec_err", 32'(out_err), 32'(vecs[i].exp_err));
      cycle(acc);
    end

    // Error counter: increment, then clear colliding with an errored transfer.
    err_clr = 1'b1;
    cycle(acc);
    err_clr = 1'b0;
    check("clr_zero", 32'(err_count), 32'd0);
    drive(1'b1, 2'd3, 32'h00000001, 32'h0000006F);
    cycle(acc);
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    cycle(acc);
    cycle(acc);
    check("errcnt_one", 32'(err_count), 32'd1);
    out_ready = 1'b0;
    drive(1'b1, 2'd3, 32'h00000003, 32'h0000006F);
    cycle(acc);
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    cycle(acc);
    out_ready = 1'b1;
    err_clr = 1'b1;
    cycle(acc);
    err_clr = 1'b0;
    check("clr_vs_xfer", 32'(err_count), 32'd0);

    // Three back-to-back requests with a 3-cycle consumer stall.
    start_x = transfers;
    idx = 0;
    hold = 0;
    first_seen = 1'b0;
    held_instr = 32'd0;
    for (int c = 0; c < 40; c++) begin
      if (idx < 3) drive(1'b1, vecs[idx].op, vecs[idx].imm, vecs[idx].base);
      else drive(1'b0, 2'd0, 32'd0, 32'd0);
      if (out_valid && !first_seen) begin
        first_seen = 1'b1;
        hold = 3;
        held_instr = out_instr;
      end else if (hold > 0) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_instr", out_instr, held_instr);
      end
      out_ready = (hold == 0);
      cycle(acc);
      if (acc) idx++;
      if (hold > 0) hold--;
      if (transfers - start_x == 3) break;
    end
    out_ready = 1'b1;
    check("stall_delivered", 32'(transfers - start_x), 32'd3);

    // Saturation with 256 errored transfers.
    err_clr = 1'b1;
    cycle(acc);
    err_clr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), ($urandom & 32'h7FFFFFFF) | 32'h00100001, $urandom);
      cycle(acc);
    end
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) cycle(acc);
    check("sat_255", 32'(err_count), 32'd255);

    // Reset with two requests in flight.
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 32'h00000005, 32'h00000013);
    cycle(acc);
    drive(1'b1, 2'd1, 32'h00000007, 32'h00002023);
    cycle(acc);
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    rst = 1'b1;
    cycle(acc);
    check("rst_flush_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    start_x = transfers;
    for (int i = 0; i < 6; i++) cycle(acc);
    check("rst_flush_none", 32'(transfers - start_x), 32'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), rand_imm(), $urandom);
      out_ready = $urandom_range(0, 9) < 7;
      err_clr = $urandom_range(0, 19) == 0;
      cycle(acc);
    end
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    out_ready = 1'b1;
    err_clr = 1'b0;
    for (int i = 0; i < 5; i++) cycle(acc);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
